bus_protocol_master: RTL and testbench

BUS_PROTOCOL_MASTER -- requirements
Module: bus_protocol_master

---
 rtl/bus_protocol_master.sv | 136 +++++++++++++
 tb/tb_bus_protocol_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_protocol_master.sv
// Byte FIFO feeding a valid/ack bus master with a 2..4 cycle valid window.
// Optional RETRY_LIMIT_EN: drop a byte after 3 consecutive timeouts (drop_err).
module bus_protocol_master #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  input  logic       dAck,
  output logic       dValid,
  output logic [7:0] data,
  output logic       done,
`ifdef RETRY_LIMIT_EN
  output logic       drop_err,
`endif
  output logic       timeout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] VALID = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]    state;
  logic [2:0]    k;
  logic          pend;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;
  logic          ack_end;
  logic          to_end;
  logic          drop;

  assign full    = (cnt == CNT_FULL);
  assign dValid  = (state == VALID);
  assign push    = wr_en & ~full;
  assign ack_end = dValid & (k >= 3'd2) & (dAck | pend);
  assign to_end  = dValid & (k == 3'd4) & ~ack_end;
  assign pop     = ack_end | drop;

`ifdef RETRY_LIMIT_EN
  logic [1:0] tcnt;

  assign drop = to_end & (tcnt == 2'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt     <= 2'd0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= drop;
      if (pop)
        tcnt <= 2'd0;
      else if (to_end)
        tcnt <= tcnt + 2'd1;
    end
  end
`else
  assign drop = 1'b0;
`endif

  // Storage needs no reset: it is only read while cnt is non-zero.
  always_ff @(posedge clk) begin
    if (push)
      mem[wp] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      k       <= 3'd0;
      pend    <= 1'b0;
      data    <= 8'h00;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done    <= ack_end;
      timeout <= to_end;
      unique case (1'b1)
        (state == VALID): begin
          if (ack_end || to_end) begin
            state <= GAP;
            k     <= 3'd0;
            pend  <= 1'b0;
          end else begin
            k <= k + 3'd1;
            // an ack in the first cycle is held until cycle 2 ends
            if (k == 3'd1 && dAck)
              pend <= 1'b1;
          end
        end
        (state == IDLE),
        (state == GAP): begin
          if (cnt != '0) begin
            state <= VALID;
            k     <= 3'd1;
            pend  <= 1'b0;
            data  <= mem[rp];
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          k     <= 3'd0;
          pend  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_protocol_master.sv
// Randomised + directed bench for bus_protocol_master against a queue model.
// Honours RETRY_LIMIT_EN when defined.
module tb_bus_protocol_master;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic       dAck = 1'b0;
  logic       dValid;
  logic [7:0] data;
  logic       done;
  logic       timeout;
`ifdef RETRY_LIMIT_EN
  logic       drop_err;
`endif

  bus_protocol_master #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .dAck    (dAck),
    .dValid  (dValid),
    .data    (data),
    .done    (done),
`ifdef RETRY_LIMIT_EN
    .drop_err(drop_err),
`endif
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model of the bus as seen after each edge
  logic [7:0] q[$];
  bit         m_busy;
  int         m_cyc;
  int         m_ack_at;
  logic [7:0] m_data;
  bit         m_done;
  bit         m_to;
  bit         m_drop;
  int         m_tries;

  // 0 never ack, 1..4 ack in that valid cycle, 5 random
  int ack_pol = 0;

  int obs_v, obs_done, obs_to, obs_rise, obs_drop;
  int cyc_no, first_v, last_v;
  bit prev_v;
  logic [7:0] sent[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_cyc = 0; m_ack_at = 0;
    m_data = 8'h00; m_done = 0; m_to = 0;
    m_drop = 0; m_tries = 0;
  endtask

  task automatic clr_obs();
    obs_v = 0; obs_done = 0; obs_to = 0;
    obs_rise = 0; obs_drop = 0;
    first_v = -1; last_v = -1;
    sent.delete();
  endtask

  task automatic model_edge(input bit wr, input logic [7:0] wd,
                            input bit ack);
    int  n0;
    bit  popped;
    n0 = q.size();
    popped = 0;
    m_done = 0; m_to = 0; m_drop = 0;
    if (m_busy) begin
      if (ack && m_ack_at == 0)
        m_ack_at = m_cyc;
      if (m_ack_at != 0 && m_cyc >= 2) begin
        m_done = 1; popped = 1; m_busy = 0; m_tries = 0;
      end else if (m_cyc == 4) begin
        m_to = 1; m_busy = 0; m_tries++;
`ifdef RETRY_LIMIT_EN
        if (m_tries == 3) begin
          m_drop = 1; popped = 1; m_tries = 0;
        end
`endif
      end else begin
        m_cyc++;
      end
      if (!m_busy)
        m_cyc = 0;
    end else if (n0 > 0) begin
      m_busy = 1; m_cyc = 1; m_ack_at = 0; m_data = q[0];
    end
    if (popped)
      void'(q.pop_front());
    if (wr && n0 < DEPTH)
      q.push_back(wd);
  endtask

  task automatic tick(input bit wr, input logic [7:0] wd);
    bit a;
    wr_en = wr;
    wr_data = wd;
    if (ack_pol == 5)
      a = bit'($urandom_range(0, 1));
    else
      a = m_busy && (m_cyc == ack_pol);
    dAck = a;
    @(posedge clk);
    model_edge(wr, wd, a);
    @(negedge clk);
    cyc_no++;
    chk("dValid", dValid, m_busy);
    chk("data", data, m_data);
    chk("done", done, m_done);
    chk("timeout", timeout, m_to);
    chk("full", full, q.size() == DEPTH);
`ifdef RETRY_LIMIT_EN
    chk("drop_err", drop_err, m_drop);
    if (drop_err) obs_drop++;
`endif
    if (dValid) begin
      obs_v++;
      if (first_v < 0) first_v = cyc_no;
      last_v = cyc_no;
      if (!prev_v) obs_rise++;
    end
    prev_v = dValid;
    if (done) begin
      obs_done++;
      sent.push_back(data);
    end
    if (timeout) obs_to++;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      tick(1'b0, 8'h00);
  endtask

  initial begin
    model_reset();
    clr_obs();
    cyc_no = 0;
    prev_v = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_dValid", dValid, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_full", full, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    reset = 1'b0;

    // ack at end of cycle 2
    clr_obs(); ack_pol = 2;
    tick(1'b1, 8'hA5);
    idle(8);
    chk("a5_vlen", obs_v, 2);
    chk("a5_done", obs_done, 1);
    chk("a5_byte", sent.size() > 0 ? sent[0] : 8'hxx, 8'hA5);

    // never acked: three full timeouts
    clr_obs(); ack_pol = 0;
    tick(1'b1, 8'h3C);
    idle(15);
    chk("3c_to", obs_to, 3);
    chk("3c_vlen", obs_v, 12);
    chk("3c_rises", obs_rise, 3);
    ack_pol = 2;
    idle(8);
`ifdef RETRY_LIMIT_EN
    chk("3c_drop", obs_drop, 1);
    chk("3c_done", obs_done, 0);
`else
    chk("3c_done", obs_done, 1);
    chk("3c_resent", sent.size() > 0 ? sent[0] : 8'hxx, 8'h3C);
`endif

    // ack at end of cycle 1 still gives two valid cycles
    clr_obs(); ack_pol = 1;
    tick(1'b1, 8'h5A);
    idle(8);
    chk("c1_vlen", obs_v, 2);
    chk("c1_done", obs_done, 1);

    // overfill the FIFO
    clr_obs(); ack_pol = 0;
    for (int i = 1; i <= 4; i++)
      tick(1'b1, 8'(i));
    chk("ov_full", full, 1'b1);
    tick(1'b1, 8'h05);
    ack_pol = 2;
    idle(40);
    chk("ov_cnt", sent.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("ov_order", i < sent.size() ? sent[i] : 8'hxx, 8'(i + 1));

    // reset in valid cycle 3
    clr_obs(); ack_pol = 0;
    tick(1'b1, 8'h77);
    tick(1'b1, 8'h88);
    idle(2);
    chk("mr_pre", dValid, 1'b1);
    reset = 1'b1;
    #1;
    chk("mr_dValid", dValid, 1'b0);
    chk("mr_data", data, 8'h00);
    chk("mr_full", full, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    prev_v = 0;
    clr_obs(); ack_pol = 2;
    idle(8);
    chk("mr_nodone", obs_done, 0);
    chk("mr_novalid", obs_v, 0);

    // back-to-back with ack in cycle 3
    clr_obs(); ack_pol = 3;
    for (int i = 0; i < 4; i++)
      tick(1'b1, 8'h10 + 8'(i));
    idle(30);
    chk("bb_vlen", obs_v, 12);
    chk("bb_rises", obs_rise, 4);
    chk("bb_span", last_v - first_v + 1, 15);
    chk("bb_done", obs_done, 4);

    // random traffic, random acks (also while idle/gap)
    ack_pol = 5;
    for (int i = 0; i < 400; i++)
      tick(($urandom_range(0, 3) == 0), 8'($urandom));
    ack_pol = 2;
    idle(60);
    chk("rnd_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
